// File: rtl/button_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : button_arbiter_if
// Description : Bundles the arm / button / event-handshake signals that run
//               between the Genius game FSM, the debouncers and the arbiter.
//               The slave modport is the arbiter's view; master is the
//               game-side (or bench) view.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_arbiter_if;

  // Control from the game FSM
  logic       arm;
  // Debouncer outputs, bit i is colour i
  logic [3:0] apertado;
  logic [3:0] segurado;
  // Event handshake towards the game FSM
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_timeout;
  // Status / lamps
  logic [3:0] lamp;
  logic       busy;

  modport slave (
    input  arm,
    input  apertado,
    input  segurado,
    input  ev_ready,
    output ev_valid,
    output ev_code,
    output ev_timeout,
    output lamp,
    output busy
  );

  modport master (
    output arm,
    output apertado,
    output segurado,
    output ev_ready,
    input  ev_valid,
    input  ev_code,
    input  ev_timeout,
    input  lamp,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/button_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_arbiter
// Description : Response-window arbiter. When armed it opens a TIMEOUT-cycle
//               window, captures the first debounced press (lowest colour
//               index wins on a chord), lights that colour's lamp until every
//               button is released, then presents one colour-or-timeout event
//               over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module button_arbiter #(
  parameter int TIMEOUT = 150_000_000,
  parameter int TIMER_W = 28
) (
  input  wire               clk,
  input  wire               reset,
  button_arbiter_if.slave   bus_io
);

  // Window reload value: the window spans TIMEOUT cycles counting down to 0.
  localparam logic [TIMER_W-1:0] C_TIMER_LOAD = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_PRESENT      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         code_q, code_d;
  logic               timeout_q, timeout_d;
  logic [3:0]         lamp_q, lamp_d;

  logic [1:0]         w_first_idx;
  logic [3:0]         w_first_onehot;

  // Lowest-index priority encode of the press pulses (colour 0 wins a chord).
  always_comb begin
    w_first_idx = 2'd0;
    casez (bus_io.apertado)
      4'b???1: w_first_idx = 2'd0;
      4'b??10: w_first_idx = 2'd1;
      4'b?100: w_first_idx = 2'd2;
      4'b1000: w_first_idx = 2'd3;
      default: w_first_idx = 2'd0;
    endcase
    w_first_onehot = 4'b0001 << w_first_idx;
  end

  // State and datapath registers; reset abandons any window without an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      code_q    <= 2'd0;
      timeout_q <= 1'b0;
      lamp_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      code_q    <= code_d;
      timeout_q <= timeout_d;
      lamp_q    <= lamp_d;
    end
  end

  // Next-state and datapath update; a press beats an expiring window.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    code_d    = code_q;
    timeout_d = timeout_q;
    lamp_d    = lamp_q;

    unique case (state_q)
      ST_IDLE: begin
        // Presses while idle are deliberately dropped.
        if (bus_io.arm) begin
          state_d   = ST_WAIT_PRESS;
          timer_d   = C_TIMER_LOAD;
          code_d    = 2'd0;
          timeout_d = 1'b0;
          lamp_d    = 4'd0;
        end
      end

      ST_WAIT_PRESS: begin
        // Only fresh pulses count, so a button already held at arm time
        // is never captured.
        if (bus_io.apertado != 4'd0) begin
          state_d = ST_WAIT_RELEASE;
          code_d  = w_first_idx;
          lamp_d  = w_first_onehot;
        end else if (timer_q == '0) begin
          state_d   = ST_PRESENT;
          timeout_d = 1'b1;
          code_d    = 2'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      ST_WAIT_RELEASE: begin
        // Extra pulses are ignored; wait indefinitely for a full release.
        if (bus_io.segurado == 4'd0) begin
          state_d = ST_PRESENT;
          lamp_d  = 4'd0;
        end
      end

      ST_PRESENT: begin
        // arm is ignored here, even in the handshake cycle.
        if (bus_io.ev_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs come straight from registers or a state decode only.
  assign bus_io.ev_valid   = (state_q == ST_PRESENT);
  assign bus_io.busy       = (state_q != ST_IDLE);
  assign bus_io.ev_code    = code_q;
  assign bus_io.ev_timeout = timeout_q;
  assign bus_io.lamp       = lamp_q;

endmodule
`default_nettype wire

// File: tb/tb_button_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_arbiter
// Description : Self-checking bench for button_arbiter (TIMEOUT = 20).
//               Expected events are queued as {timeout, code} when the
//               stimulus that causes them is driven, and popped when the
//               DUT raises ev_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_arbiter;

  localparam int C_TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset;

  button_arbiter_if bif ();

  button_arbiter #(
    .TIMEOUT (C_TIMEOUT),
    .TIMER_W (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bif)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] sb_q[$];

  // Advance one cycle; inputs/outputs are handled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive arm for one cycle t; returns in cycle t+1.
  task automatic arm_once();
    bif.arm = 1'b1;
    tick();
    bif.arm = 1'b0;
  endtask

  // Wait (bounded) for ev_valid, then pop and compare the expected event.
  task automatic sb_consume(input string name, input int bound);
    int         n;
    logic [2:0] exp_ev;
    n = 0;
    while (!bif.ev_valid && n < bound) begin
      tick();
      n++;
    end
    n_cmp++;
    if (bif.ev_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_valid: got %b expected 1 within %0d cycles", name, bif.ev_valid, bound);
    end else if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_sb: got event %b with no expected event queued", name,
               {bif.ev_timeout, bif.ev_code});
    end else begin
      exp_ev = sb_q.pop_front();
      if ({bif.ev_timeout, bif.ev_code} !== exp_ev) begin
        n_err++;
        $display("FAIL %s_event: got {to,code}=%b expected %b", name,
                 {bif.ev_timeout, bif.ev_code}, exp_ev);
      end
    end
  endtask

  // One-cycle ready pulse; valid and busy must both drop next cycle.
  task automatic accept(input string name);
    bif.ev_ready = 1'b1;
    tick();
    bif.ev_ready = 1'b0;
    n_cmp++;
    if ({bif.ev_valid, bif.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s_accept: got {valid,busy}=%b expected 00", name, {bif.ev_valid, bif.busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.arm = 1'b1;
    bif.apertado = 4'hF;
    bif.segurado = 4'hF;
    bif.ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bif.ev_valid, bif.ev_code, bif.ev_timeout, bif.lamp, bif.busy} !== 9'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got %b expected 0", {bif.ev_valid, bif.ev_code,
                 bif.ev_timeout, bif.lamp, bif.busy});
      end
    end
    reset = 1'b0;
    bif.arm = 1'b0;
    bif.apertado = 4'h0;
    bif.segurado = 4'h0;
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b expected 0", bif.busy);
    end
    arm_once();
    sb_q.push_back(3'b100);
    n_cmp++;
    if (bif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_arm_busy: got %b expected 1", bif.busy);
    end
    sb_consume("reset_first_window", C_TIMEOUT + 2);
    accept("reset_first_window");
  endtask

  task automatic test_single_press();
    logic [3:0] lamp_bad;
    arm_once();
    repeat (4) tick();
    bif.apertado = 4'b0100;
    bif.segurado = 4'b0100;
    sb_q.push_back(3'b010);
    tick();
    bif.apertado = 4'b0000;
    lamp_bad = 4'd0;
    for (int k = 6; k <= 9; k++) begin
      if (k == 9) bif.segurado = 4'b0000;
      if (bif.lamp !== 4'b0100 || bif.ev_valid !== 1'b0) lamp_bad[k-6] = 1'b1;
      if (k != 9) tick();
    end
    n_cmp++;
    if (lamp_bad !== 4'd0) begin
      n_err++;
      $display("FAIL single_lamp_window: bad cycles %b expected 0000", lamp_bad);
    end
    tick();
    n_cmp++;
    if ({bif.ev_valid, bif.lamp} !== 5'b10000) begin
      n_err++;
      $display("FAIL single_valid_at_t10: got {valid,lamp}=%b expected 10000", {bif.ev_valid, bif.lamp});
    end
    repeat (3) tick();
    n_cmp++;
    if ({bif.ev_valid, bif.ev_timeout, bif.ev_code} !== 4'b1010) begin
      n_err++;
      $display("FAIL single_hold: got %b expected 1010", {bif.ev_valid, bif.ev_timeout, bif.ev_code});
    end
    sb_consume("single", 0);
    accept("single");
  endtask

  task automatic test_timeout();
    // No press: event must appear at t+21, not t+20.
    arm_once();
    sb_q.push_back(3'b100);
    repeat (C_TIMEOUT - 1) tick();
    n_cmp++;
    if (bif.ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: got valid %b expected 0 at t+20", bif.ev_valid);
    end
    tick();
    n_cmp++;
    if (bif.ev_valid !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_at_t21: got valid %b expected 1", bif.ev_valid);
    end
    sb_consume("timeout", 0);
    accept("timeout");
    // Press in the last window cycle wins over the timeout.
    arm_once();
    repeat (C_TIMEOUT - 1) tick();
    bif.apertado = 4'b0001;
    sb_q.push_back(3'b000);
    tick();
    bif.apertado = 4'b0000;
    n_cmp++;
    if ({bif.lamp, bif.ev_valid} !== 5'b00010) begin
      n_err++;
      $display("FAIL timeout_lastpress_lamp: got {lamp,valid}=%b expected 00010", {bif.lamp, bif.ev_valid});
    end
    tick();
    sb_consume("timeout_lastpress", 0);
    accept("timeout_lastpress");
  endtask

  task automatic test_chord();
    arm_once();
    repeat (2) tick();
    bif.apertado = 4'b1010;
    bif.segurado = 4'b1010;
    sb_q.push_back(3'b001);
    tick();
    bif.apertado = 4'b0000;
    n_cmp++;
    if (bif.lamp !== 4'b0010) begin
      n_err++;
      $display("FAIL chord_lamp: got %b expected 0010", bif.lamp);
    end
    bif.apertado = 4'b0001;
    bif.segurado = 4'b1011;
    tick();
    bif.apertado = 4'b0000;
    bif.segurado = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({bif.ev_valid, bif.lamp} !== 5'b00010) begin
        n_err++;
        $display("FAIL chord_held: got {valid,lamp}=%b expected 00010", {bif.ev_valid, bif.lamp});
      end
    end
    bif.segurado = 4'b0000;
    tick();
    sb_consume("chord", 0);
    accept("chord");
  endtask

  task automatic test_ignored_arms();
    // Button held at arm time, arm retriggered mid-window: still t+21 timeout.
    bif.segurado = 4'b0001;
    arm_once();
    sb_q.push_back(3'b100);
    repeat (3) tick();
    bif.arm = 1'b1;
    tick();
    bif.arm = 1'b0;
    repeat (15) tick();
    n_cmp++;
    if ({bif.ev_valid, bif.lamp} !== 5'b00000) begin
      n_err++;
      $display("FAIL held_early: got {valid,lamp}=%b expected 00000", {bif.ev_valid, bif.lamp});
    end
    tick();
    sb_consume("held_timeout", 0);
    bif.segurado = 4'b0000;
    bif.arm = 1'b1;
    tick();
    n_cmp++;
    if (bif.ev_valid !== 1'b1) begin
      n_err++;
      $display("FAIL present_arm: got valid %b expected 1", bif.ev_valid);
    end
    bif.ev_ready = 1'b1;
    tick();
    bif.ev_ready = 1'b0;
    bif.arm = 1'b0;
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL handshake_arm: got busy %b expected 0", bif.busy);
    end
    // ready while idle is ignored
    bif.ev_ready = 1'b1;
    tick();
    bif.ev_ready = 1'b0;
    n_cmp++;
    if ({bif.busy, bif.ev_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_ready: got {busy,valid}=%b expected 00", {bif.busy, bif.ev_valid});
    end
    // arm during WAIT_RELEASE
    arm_once();
    bif.apertado = 4'b0100;
    bif.segurado = 4'b0100;
    sb_q.push_back(3'b010);
    tick();
    bif.apertado = 4'b0000;
    bif.arm = 1'b1;
    tick();
    bif.arm = 1'b0;
    n_cmp++;
    if (bif.lamp !== 4'b0100) begin
      n_err++;
      $display("FAIL release_arm_lamp: got %b expected 0100", bif.lamp);
    end
    bif.segurado = 4'b0000;
    tick();
    sb_consume("release_arm", 0);
    accept("release_arm");
  endtask

  task automatic test_reset_mid();
    int seen_valid;
    arm_once();
    bif.apertado = 4'b0001;
    bif.segurado = 4'b0001;
    tick();
    bif.apertado = 4'b0000;
    n_cmp++;
    if (bif.lamp !== 4'b0001) begin
      n_err++;
      $display("FAIL midreset_lamp_before: got %b expected 0001", bif.lamp);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bif.segurado = 4'b0000;
    n_cmp++;
    if ({bif.lamp, bif.busy} !== 5'b00000) begin
      n_err++;
      $display("FAIL midreset_after: got {lamp,busy}=%b expected 00000", {bif.lamp, bif.busy});
    end
    seen_valid = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bif.ev_valid !== 1'b0 || bif.busy !== 1'b0) seen_valid++;
    end
    n_cmp++;
    if (seen_valid != 0) begin
      n_err++;
      $display("FAIL midreset_no_event: got %0d active cycles expected 0", seen_valid);
    end
    arm_once();
    sb_q.push_back(3'b100);
    repeat (C_TIMEOUT - 1) tick();
    n_cmp++;
    if (bif.ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_rearm_early: got valid %b expected 0", bif.ev_valid);
    end
    tick();
    sb_consume("midreset_rearm", 0);
    accept("midreset_rearm");
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d queued events expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_timeout();
    test_chord();
    test_ignored_arms();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/button_arbiter.md
# button_arbiter

Response-window arbiter sitting between the four per-colour debouncers and the Genius game FSM. When the FSM arms it, it opens a timed window, accepts the first debounced press (`apertado` pulse), and lights that colour's lamp while the button is held. It waits for all buttons to be released, then presents a single colour-or-timeout event to the FSM over a valid/ready handshake. This keeps chords, repeated pulses and held buttons from ever reaching game logic.

## Interface

Parameters:
- `TIMEOUT`, default 150_000_000: length of the response window in clk cycles (3 s at 50 MHz). Legal range is 1 ≤ TIMEOUT < 2^TIMER_W.
- `TIMER_W`, default 28: width of the window down-counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `arm`  in  1  request to open a response window. Honoured only in IDLE.
- `apertado`  in  4  one-cycle press pulses from debouncers. Bit i is colour i.
- `segurado`  in  4  debounced held levels from debouncers.
- `ev_ready`  in  1  FSM accepts the presented event.
- `ev_valid`  out  1  event presented. Held until accepted.
- `ev_code`  out  2  captured colour index. 0 on timeout.
- `ev_timeout`  out  1  1 means the window expired with no press.
- `lamp`  out  4  one-hot of the captured colour, asserted only while waiting for release.
- `busy`  out  1  high in every state except IDLE.

## Operation

The block is a four-state FSM: IDLE, WAIT_PRESS, WAIT_RELEASE, PRESENT.

- **Reset:** state = IDLE; timer = 0; `ev_valid`, `ev_code`, `ev_timeout`, `lamp` and `busy` are all 0. Reset mid-window abandons the window with no event; reset dominates all other inputs.
- **IDLE:**
  - `arm` = 1 → WAIT_PRESS, timer ← TIMEOUT−1, `ev_code` ← 0, `ev_timeout` ← 0.
  - Pulses on `apertado` are ignored.
- **WAIT_PRESS**, evaluated each cycle, with press taking priority over timeout:
  - `apertado` ≠ 0: capture `ev_code` = lowest set bit index (priority to colour 0), set `lamp` = one-hot(code), go to WAIT_RELEASE.
  - Otherwise, timer = 0: `ev_timeout` ← 1, `ev_code` ← 0, go to PRESENT.
  - Otherwise: timer ← timer−1.
  - Buttons already held when arm arrives produce no pulse and are not accepted.
- **WAIT_RELEASE:**
  - `lamp` stays asserted.
  - `segurado` = 0 (all four released) → `lamp` ← 0, go to PRESENT.
  - Further `apertado` pulses are ignored and do not change the code.
  - There is no timeout in this state.
- **PRESENT:**
  - `ev_valid` = 1; `ev_code` and `ev_timeout` are held stable.
  - `ev_ready` = 1 → IDLE, `ev_valid` ← 0.
  - `arm` is ignored here, including in the cycle of the handshake. The FSM must re-arm from IDLE.
- `arm` in any state other than IDLE has no effect.
- **Output encoding:** `ev_code` and `ev_timeout` are registered. `busy` and `ev_valid` are decoded from the state register. No output is combinational from any input.

## Timing

- `arm` sampled high in IDLE at cycle t → `busy` = 1 at t+1. The first press is accepted from cycle t+1.
- WAIT_PRESS lasts at most TIMEOUT cycles, t+1 … t+TIMEOUT.
  - A press in cycle t+TIMEOUT is accepted (press wins over timeout).
  - With no press, `ev_valid` = 1 and `ev_timeout` = 1 at t+TIMEOUT+1.
- Press accepted at cycle c → `lamp` valid at c+1.
- `segurado` = 0 sampled at cycle r in WAIT_RELEASE → `lamp` = 0 and `ev_valid` = 1 at r+1. Minimum press-to-valid latency is 2 cycles, when the release is already seen in cycle c+1.
- `ev_valid` ∧ `ev_ready` at cycle p → `ev_valid` = 0 and `busy` = 0 at p+1. The earliest re-arm is sampled at p+1.
- `ev_ready` while `ev_valid` = 0 is ignored.
- With TIMEOUT = 1, WAIT_PRESS lasts exactly one cycle.

## Test plan

- **Reset values:** hold reset for 3 cycles with `arm` = 1 and `apertado` = 4'hF → all outputs 0 and `busy` = 0 throughout; after release of reset, `busy` = 1 exactly one cycle after the first `arm` sample.
- **Single press:**
  - Stimulus: TIMEOUT = 20; arm at t; `apertado` = 4'b0100 and `segurado` = 4'b0100 at t+5; `segurado` = 0 at t+9; `ev_ready` held 0.
  - Response: `lamp` = 4'b0100 during t+6…t+9; `ev_valid` = 1, `ev_code` = 2, `ev_timeout` = 0 from t+10, held stable.
  - Then assert `ev_ready` for one cycle → `ev_valid` = 0 and `busy` = 0 on the next cycle.
- **Timeout:**
  - TIMEOUT = 20, arm at t, no presses → `ev_valid` = 1, `ev_timeout` = 1, `ev_code` = 0 first at t+21, and not at t+20.
  - Separately, a press at exactly t+20 → accepted as a colour event, not a timeout.
- **Chord and extra pulses:**
  - `apertado` = 4'b1010 in one cycle → `ev_code` = 1, `lamp` = 4'b0010.
  - A later pulse on bit 0 during WAIT_RELEASE → code stays 1.
  - `segurado` = 4'b1000 held → PRESENT is not reached until it drops to 0.
- **Ignored arms and held buttons:**
  - Arm while `segurado` = 4'b0001 with no `apertado` pulse → no capture, and timeout occurs.
  - `arm` pulsed during WAIT_PRESS, WAIT_RELEASE and PRESENT (including the handshake cycle) → no restart; IDLE is reached after the handshake.
- **Reset mid-operation:** reset in WAIT_RELEASE with `lamp` = 4'b0001 → next cycle `lamp` = 0, `busy` = 0, no `ev_valid` ever; a subsequent arm behaves as from power-up.
